// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one word-address request at a time
// to instruction memory, and queues returned instructions in a small FIFO that
// decode drains. Redirects flush the FIFO and mark any in-flight response stale.
module instr_fetch_unit #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,

    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_resp_valid,
    input  logic [WORD_W-1:0] imem_resp_data,

    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,

    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [WORD_W-1:0] dec_instr,
    output logic [ADDR_W-1:0] dec_pc
);

    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam int unsigned      CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_PC);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StWaitDrop
    } state_e;

    state_e            r_state, w_state_d;
    logic [ADDR_W-1:0] r_pc, w_pc_d;
    logic [ADDR_W-1:0] r_req_pc, w_req_pc_d;
    logic [CNT_W-1:0]  r_count, w_count_d;
    logic [PTR_W-1:0]  r_head, w_head_d;
    logic [PTR_W-1:0]  r_tail, w_tail_d;

    logic [WORD_W-1:0] r_buf_instr [DEPTH];
    logic [ADDR_W-1:0] r_buf_pc    [DEPTH];

    logic w_accept;
    logic w_push;
    logic w_pop;

    // A slot is reserved at issue time, so a kept response can never overflow.
    assign imem_req_valid = !rst && (r_state == StIdle) && (r_count < FULL_CNT);
    assign imem_addr      = r_pc;
    assign dec_valid      = (r_count != '0);
    assign dec_instr      = r_buf_instr[r_head];
    assign dec_pc         = r_buf_pc[r_head];

    assign w_accept = imem_req_valid && imem_req_ready;
    // Redirect wins over any same-cycle push or pop.
    assign w_push   = !redirect_valid && (r_state == StWait) && imem_resp_valid;
    assign w_pop    = !redirect_valid && dec_valid && dec_ready;

    // Next-state logic for the request FSM, PC and FIFO pointers.
    always_comb begin
        w_state_d  = r_state;
        w_pc_d     = r_pc;
        w_req_pc_d = r_req_pc;
        w_count_d  = r_count;
        w_head_d   = r_head;
        w_tail_d   = r_tail;

        if (redirect_valid) begin
            w_pc_d    = redirect_pc;
            w_count_d = '0;
            w_head_d  = '0;
            w_tail_d  = '0;
            // A response landing this cycle completes its request; otherwise any
            // outstanding or newly accepted request must have its data dropped.
            if (((r_state != StIdle) && !imem_resp_valid) || w_accept) begin
                w_state_d = StWaitDrop;
            end else begin
                w_state_d = StIdle;
            end
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        w_req_pc_d = r_pc;
                        w_pc_d     = r_pc + ADDR_W'(1);
                        w_state_d  = StWait;
                    end
                end
                StWait: begin
                    if (imem_resp_valid) w_state_d = StIdle;
                end
                StWaitDrop: begin
                    if (imem_resp_valid) w_state_d = StIdle;
                end
                default: w_state_d = StIdle;
            endcase

            if (w_push) w_tail_d = r_tail + PTR_W'(1);
            if (w_pop)  w_head_d = r_head + PTR_W'(1);

            case ({w_push, w_pop})
                2'b10:   w_count_d = r_count + CNT_W'(1);
                2'b01:   w_count_d = r_count - CNT_W'(1);
                default: w_count_d = r_count;
            endcase
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_pc     <= RST_PC;
            r_req_pc <= '0;
            r_count  <= '0;
            r_head   <= '0;
            r_tail   <= '0;
        end else begin
            r_state  <= w_state_d;
            r_pc     <= w_pc_d;
            r_req_pc <= w_req_pc_d;
            r_count  <= w_count_d;
            r_head   <= w_head_d;
            r_tail   <= w_tail_d;
        end
    end

    // FIFO storage; cleared on reset so decode outputs read zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf_instr[i] <= '0;
                r_buf_pc[i]    <= '0;
            end
        end else if (w_push) begin
            r_buf_instr[r_tail] <= imem_resp_data;
            r_buf_pc[r_tail]    <= r_req_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a behavioural memory with random latency
// and a queue-based model of the fetch buffer predict every output each cycle.
module tb_instr_fetch_unit;

    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned RESET_PC = 0;
    localparam int unsigned DEPTH    = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_resp_valid;
    logic [WORD_W-1:0] imem_resp_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              dec_valid;
    logic              dec_ready;
    logic [WORD_W-1:0] dec_instr;
    logic [ADDR_W-1:0] dec_pc;

    instr_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .WORD_W   (WORD_W),
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_instr       (dec_instr),
        .dec_pc          (dec_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WORD_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return 32'h0000_0100 + {16'h0000, a};
    endfunction

    // Stimulus knobs (percent probabilities, max extra memory latency).
    int p_rst   = 0;
    int p_ready = 100;
    int p_dec   = 100;
    int p_redir = 0;
    int max_lat = 0;

    // Memory model.
    bit                mem_busy = 1'b0;
    int                mem_wait = 0;
    logic [ADDR_W-1:0] mem_addr = '0;

    // Reference model.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } ent_t;
    ent_t              m_buf[$];
    logic [ADDR_W-1:0] m_pc     = ADDR_W'(RESET_PC);
    logic [ADDR_W-1:0] m_req_pc = '0;
    bit                m_out    = 1'b0;
    bit                m_drop   = 1'b0;
    bit                m_fresh  = 1'b1;

    function automatic logic [ADDR_W-1:0] pick_target();
        case ($urandom_range(3))
            0:       return 16'hFFFF;
            1:       return 16'hFFFE;
            2:       return 16'h0040;
            default: return ADDR_W'($urandom());
        endcase
    endfunction

    task automatic step();
        bit exp_rv;
        bit m_acc;
        bit had;
        bit acc_dut;

        @(negedge clk);
        rst             = ($urandom_range(99) < p_rst);
        imem_req_ready  = ($urandom_range(99) < p_ready);
        dec_ready       = ($urandom_range(99) < p_dec);
        redirect_valid  = !rst && ($urandom_range(99) < p_redir);
        redirect_pc     = pick_target();
        imem_resp_valid = !rst && mem_busy && (mem_wait == 0);
        imem_resp_data  = imem_resp_valid ? mem_word(mem_addr) : $urandom();
        #1;

        exp_rv = !rst && !m_out && (m_buf.size() < DEPTH);
        check_eq("imem_req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        check_eq("imem_addr", {16'b0, imem_addr}, {16'b0, m_pc});
        check_eq("dec_valid", {31'b0, dec_valid}, {31'b0, m_buf.size() != 0});
        if (m_buf.size() != 0) begin
            check_eq("dec_instr", dec_instr, m_buf[0].instr);
            check_eq("dec_pc", {16'b0, dec_pc}, {16'b0, m_buf[0].pc});
        end else if (m_fresh) begin
            check_eq("dec_instr_rst", dec_instr, 32'h0);
            check_eq("dec_pc_rst", {16'b0, dec_pc}, 32'h0);
        end

        // Memory reacts to the DUT's actual handshake.
        acc_dut = imem_req_valid && imem_req_ready;
        if (rst) begin
            mem_busy = 1'b0;
        end else begin
            if (imem_resp_valid) mem_busy = 1'b0;
            else if (mem_busy) mem_wait--;
            if (acc_dut) begin
                if (mem_busy) check_eq("single_outstanding", 32'h1, 32'h0);
                mem_busy = 1'b1;
                mem_addr = imem_addr;
                mem_wait = $urandom_range(max_lat, 0);
            end
        end

        // Model update for the coming edge.
        m_acc = exp_rv && imem_req_ready;
        if (rst) begin
            m_buf.delete();
            m_pc    = ADDR_W'(RESET_PC);
            m_out   = 1'b0;
            m_drop  = 1'b0;
            m_fresh = 1'b1;
        end else if (redirect_valid) begin
            m_out  = (m_out && !imem_resp_valid) || m_acc;
            m_drop = m_out;
            m_buf.delete();
            m_pc   = redirect_pc;
        end else begin
            had = (m_buf.size() != 0);
            if (m_out && imem_resp_valid) begin
                if (!m_drop) begin
                    m_buf.push_back('{pc: m_req_pc, instr: mem_word(m_req_pc)});
                    m_fresh = 1'b0;
                end
                m_out = 1'b0;
            end
            if (had && dec_ready) void'(m_buf.pop_front());
            if (m_acc) begin
                m_req_pc = m_pc;
                m_pc     = m_pc + 16'd1;
                m_out    = 1'b1;
                m_drop   = 1'b0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        dec_ready       = 1'b0;
        repeat (2) @(posedge clk);

        // Reset held: outputs at reset values.
        p_rst = 100;
        run(2);

        // Streaming with a 1-cycle memory.
        p_rst = 0; p_ready = 100; p_dec = 100; p_redir = 0; max_lat = 0;
        run(20);

        // Backpressure then drain.
        p_dec = 0;
        run(10);
        p_dec = 100;
        run(10);

        // Random latency, handshake and occasional redirects.
        p_ready = 70; p_dec = 60; p_redir = 10; max_lat = 3;
        run(400);

        // Heavy redirects, short latency to hit same-cycle response/pop cases.
        p_redir = 35; max_lat = 1; p_dec = 80;
        run(300);

        // Occasional mid-operation reset.
        p_redir = 10; p_rst = 3; max_lat = 3; p_dec = 40;
        run(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
